// File: rtl/uart_tx_if.sv
// Byte handshake and serial-line bundle for the UART transmitter.
interface uart_tx_if;
    logic [7:0] data_in;
    logic       in_valid;
    logic       in_ready;
    logic       tx;
    logic       busy;
    logic       done;

    // Producer side: drives the byte and its valid, observes the line and status.
    modport master (
        output data_in,
        output in_valid,
        input  in_ready,
        input  tx,
        input  busy,
        input  done
    );

    // Transmitter side.
    modport slave (
        input  data_in,
        input  in_valid,
        output in_ready,
        output tx,
        output busy,
        output done
    );
endinterface

// File: rtl/uart_tx.sv
// UART serial transmitter: start bit, 8 data bits LSB first, optional parity,
// one or two stop bits. All outputs are registered.
module uart_tx #(
    parameter int unsigned CLK_DIV    = 5208,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic     sys_clk,
    input  logic     rst,
    uart_tx_if.slave bus
);
    localparam int unsigned CntW     = $clog2(CLK_DIV);
    localparam logic [CntW-1:0] BaudLast = CntW'(CLK_DIV - 1);
    localparam logic [2:0]  StopLast = 3'(STOP_BITS - 1);
    localparam logic        ParOdd   = (PARITY_ODD != 0);
    localparam logic        ParEn    = (PARITY_EN != 0);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e          state_q;
    logic [CntW-1:0] baud_q;
    logic [2:0]      bit_q;      // data bit index in DATA, stop bit index in STOP
    logic [7:0]      shift_q;
    logic [7:0]      byte_q;     // untouched copy of the accepted byte for parity
    logic            tx_q;
    logic            in_ready_q;
    logic            busy_q;
    logic            done_q;

    logic baud_end;
    logic par_bit;

    // Bit-end strobe and parity of the latched byte.
    always_comb begin
        baud_end = (baud_q == BaudLast);
        par_bit  = (^byte_q) ^ ParOdd;
    end

    // Frame FSM; tx/in_ready/busy/done are loaded alongside each state change.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q    <= StIdle;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            byte_q     <= '0;
            tx_q       <= 1'b1;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state_q == StIdle) begin
                if (bus.in_valid && in_ready_q) begin
                    shift_q    <= bus.data_in;
                    byte_q     <= bus.data_in;
                    state_q    <= StStart;
                    baud_q     <= '0;
                    bit_q      <= '0;
                    tx_q       <= 1'b0;
                    in_ready_q <= 1'b0;
                    busy_q     <= 1'b1;
                end
            end else if (!baud_end) begin
                baud_q <= baud_q + 1'b1;
            end else begin
                baud_q <= '0;
                case (state_q)
                    StStart: begin
                        state_q <= StData;
                        tx_q    <= shift_q[0];
                    end
                    StData: begin
                        shift_q <= shift_q >> 1;
                        if (bit_q == 3'd7) begin
                            bit_q <= '0;
                            if (ParEn) begin
                                state_q <= StParity;
                                tx_q    <= par_bit;
                            end else begin
                                state_q <= StStop;
                                tx_q    <= 1'b1;
                            end
                        end else begin
                            bit_q <= bit_q + 1'b1;
                            // Shift happens on this same edge, so the next bit is [1].
                            tx_q  <= shift_q[1];
                        end
                    end
                    StParity: begin
                        state_q <= StStop;
                        tx_q    <= 1'b1;
                    end
                    StStop: begin
                        if (bit_q == StopLast) begin
                            state_q    <= StIdle;
                            bit_q      <= '0;
                            in_ready_q <= 1'b1;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                        end else begin
                            bit_q <= bit_q + 1'b1;
                        end
                        tx_q <= 1'b1;
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

    assign bus.tx       = tx_q;
    assign bus.in_ready = in_ready_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four instances (8N1, even parity, odd parity, two stop
// bits) at CLK_DIV=4, selected through a mux onto shared stimulus/observation.
module tb_uart_tx;
    localparam int unsigned Div = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         sel = 0;
    logic [7:0] data_drv = 8'h00;
    logic       valid_drv = 1'b0;
    bit         rx_discard = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    // Per-instance configuration as the bench understands it.
    bit cfg_par  [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    bit cfg_odd  [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    int cfg_stop [4] = '{1, 1, 1, 2};

    logic exp_tx[$];
    logic [7:0] exp_byte[$];

    always #5 clk = ~clk;

    uart_tx_if if0 ();
    uart_tx_if if1 ();
    uart_tx_if if2 ();
    uart_tx_if if3 ();

    assign if0.data_in  = data_drv;
    assign if1.data_in  = data_drv;
    assign if2.data_in  = data_drv;
    assign if3.data_in  = data_drv;
    assign if0.in_valid = valid_drv && (sel == 0);
    assign if1.in_valid = valid_drv && (sel == 1);
    assign if2.in_valid = valid_drv && (sel == 2);
    assign if3.in_valid = valid_drv && (sel == 3);

    uart_tx #(.CLK_DIV(Div)) u_dut0 (.sys_clk(clk), .rst(rst), .bus(if0));
    uart_tx #(.CLK_DIV(Div), .PARITY_EN(1)) u_dut1 (.sys_clk(clk), .rst(rst), .bus(if1));
    uart_tx #(.CLK_DIV(Div), .PARITY_EN(1), .PARITY_ODD(1)) u_dut2 (
        .sys_clk(clk), .rst(rst), .bus(if2));
    uart_tx #(.CLK_DIV(Div), .STOP_BITS(2)) u_dut3 (.sys_clk(clk), .rst(rst), .bus(if3));

    logic tx_s, rdy_s, busy_s, done_s;

    // Route the selected instance's outputs to the checkers.
    always_comb begin
        tx_s   = if0.tx;
        rdy_s  = if0.in_ready;
        busy_s = if0.busy;
        done_s = if0.done;
        case (sel)
            1: begin tx_s = if1.tx; rdy_s = if1.in_ready; busy_s = if1.busy; done_s = if1.done; end
            2: begin tx_s = if2.tx; rdy_s = if2.in_ready; busy_s = if2.busy; done_s = if2.done; end
            3: begin tx_s = if3.tx; rdy_s = if3.in_ready; busy_s = if3.busy; done_s = if3.done; end
            default: ;
        endcase
    end

    typedef struct {
        int         sel;
        logic [7:0] data;
        int         done_at;  // cycles from accept edge to done
        logic       par;      // expected parity bit (when enabled)
        bit         meddle;   // poke data_in/in_valid mid-frame
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected line level for every cycle of one frame.
    task automatic push_frame(input int s, input logic [7:0] d, input logic par);
        repeat (Div) exp_tx.push_back(1'b0);
        for (int i = 0; i < 8; i++) repeat (Div) exp_tx.push_back(d[i]);
        if (cfg_par[s]) repeat (Div) exp_tx.push_back(par);
        repeat (cfg_stop[s] * Div) exp_tx.push_back(1'b1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (rdy_s !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle_wait", rdy_s, 1);
    endtask

    task automatic check_tx(input string name);
        logic e = 1'bx;
        if (exp_tx.size() > 0) e = exp_tx.pop_front();
        chk(name, tx_s, e);
    endtask

    task automatic run_vec(input vec_t v);
        sel = v.sel;
        #1;
        wait_idle();
        push_frame(v.sel, v.data, v.par);
        exp_byte.push_back(v.data);
        data_drv  = v.data;
        valid_drv = 1'b1;
        @(posedge clk); #1;
        valid_drv = 1'b0;
        for (int k = 0; k < v.done_at; k++) begin
            check_tx("tx");
            chk("busy", busy_s, 1);
            chk("in_ready", rdy_s, 0);
            chk("done_early", done_s, 0);
            if (v.meddle && (k % 5 == 2)) begin
                data_drv  = 8'($urandom);
                valid_drv = 1'b1;
            end else begin
                valid_drv = 1'b0;
            end
            @(posedge clk); #1;
        end
        valid_drv = 1'b0;
        chk("frame_len", exp_tx.size(), 0);
        chk("done_pulse", done_s, 1);
        chk("ready_at_done", rdy_s, 1);
        chk("busy_at_done", busy_s, 0);
        chk("tx_idle_at_done", tx_s, 1);
        @(posedge clk); #1;
        chk("done_one_cycle", done_s, 0);
    endtask

    // Receiver model: samples mid-bit and scores decoded bytes against the queue.
    initial begin : rx_model
        logic [7:0] b;
        int s;
        forever begin
            @(posedge clk); #2;
            if (rst === 1'b0 && tx_s === 1'b0) begin
                s = sel;
                repeat (2) @(posedge clk);
                #2;
                chk("rx_start", tx_s, 0);
                for (int i = 0; i < 8; i++) begin
                    repeat (Div) @(posedge clk);
                    #2;
                    b[i] = tx_s;
                end
                if (cfg_par[s]) begin
                    repeat (Div) @(posedge clk);
                    #2;
                    chk("rx_parity", tx_s, (^b) ^ cfg_odd[s]);
                end
                repeat (Div) @(posedge clk);
                #2;
                chk("rx_stop", tx_s, 1);
                if (rx_discard) begin
                    rx_discard = 1'b0;
                end else if (exp_byte.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL rx_unexpected: got 0x%0h, expected no frame", b);
                end else begin
                    chk("rx_byte", b, exp_byte.pop_front());
                end
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "timeout");
    end

    initial begin : main
        bit saw_done;

        vecs[0] = '{sel: 0, data: 8'h55, done_at: 40, par: 1'b0, meddle: 1'b0};
        vecs[1] = '{sel: 1, data: 8'h07, done_at: 44, par: 1'b1, meddle: 1'b0};
        vecs[2] = '{sel: 2, data: 8'h07, done_at: 44, par: 1'b0, meddle: 1'b0};
        vecs[3] = '{sel: 3, data: 8'h00, done_at: 44, par: 1'b0, meddle: 1'b0};
        vecs[4] = '{sel: 0, data: 8'h12, done_at: 40, par: 1'b0, meddle: 1'b1};
        vecs[5] = '{sel: 1, data: 8'hC4, done_at: 44, par: 1'b1, meddle: 1'b0};
        vecs[6] = '{sel: 3, data: 8'hFF, done_at: 44, par: 1'b0, meddle: 1'b0};
        vecs[7] = '{sel: 2, data: 8'h00, done_at: 44, par: 1'b1, meddle: 1'b0};

        // Reset state of every instance.
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            sel = k;
            #1;
            chk("rst_tx", tx_s, 1);
            chk("rst_ready", rdy_s, 1);
            chk("rst_busy", busy_s, 0);
            chk("rst_done", done_s, 0);
        end
        sel = 0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) run_vec(vecs[i]);

        // Back-to-back: in_valid held high across two frames.
        sel = 0;
        #1;
        wait_idle();
        push_frame(0, 8'hA3, 1'b0);
        exp_tx.push_back(1'b1);
        push_frame(0, 8'h3C, 1'b0);
        exp_byte.push_back(8'hA3);
        exp_byte.push_back(8'h3C);
        data_drv  = 8'hA3;
        valid_drv = 1'b1;
        @(posedge clk); #1;
        data_drv = 8'h3C;
        for (int k = 0; k <= 80; k++) begin
            check_tx("b2b_tx");
            if (k == 40) begin
                chk("b2b_done1", done_s, 1);
                chk("b2b_ready1", rdy_s, 1);
            end
            if (k == 41) begin
                chk("b2b_accept2_busy", busy_s, 1);
                chk("b2b_accept2_ready", rdy_s, 0);
                valid_drv = 1'b0;
            end
            @(posedge clk); #1;
        end
        chk("b2b_done2", done_s, 1);
        chk("b2b_len", exp_tx.size(), 0);
        @(posedge clk); #1;

        // Reset during D3 of a 0xFF frame.
        wait_idle();
        data_drv  = 8'hFF;
        valid_drv = 1'b1;
        @(posedge clk); #1;
        valid_drv = 1'b0;
        repeat (17) @(posedge clk);
        #1;
        chk("d3_level", tx_s, 1);
        chk("d3_busy", busy_s, 1);
        rx_discard = 1'b1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_tx", tx_s, 1);
        chk("abort_ready", rdy_s, 1);
        chk("abort_busy", busy_s, 0);
        chk("abort_done", done_s, 0);
        saw_done = 1'b0;
        repeat (45) begin
            @(posedge clk); #1;
            if (done_s === 1'b1) saw_done = 1'b1;
        end
        chk("abort_no_done", saw_done, 0);
        run_vec('{sel: 0, data: 8'h81, done_at: 40, par: 1'b0, meddle: 1'b0});

        chk("tx_queue_empty", exp_tx.size(), 0);
        chk("byte_queue_empty", exp_byte.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
